// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit (0), DATA_WIDTH data bits LSB first, stop bit (1),
// each bit held for CLKS_PER_BIT clocks. Words are accepted over a valid/ready handshake.
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  busy
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [DATA_WIDTH-1:0] shift, shift_nxt, shift_sr;
    logic                  tx_out_nxt, busy_nxt;
    logic                  accept, bit_done;

    // tx_ready is forced low while reset is held so no word is lost during reset.
    assign tx_ready = (state == IDLE) && reset;
    assign accept   = tx_valid && tx_ready;
    assign bit_done = (timer == T_LAST);
    assign shift_sr = shift >> 1;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   if (bit_done) state_nxt = DATA;
            DATA:    if (bit_done && idx == I_LAST) state_nxt = STOP;
            STOP:    if (bit_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered line, busy flag and datapath.
    always_comb begin
        timer_nxt  = (state == IDLE || bit_done) ? '0 : timer + TW'(1);
        idx_nxt    = idx;
        shift_nxt  = shift;
        tx_out_nxt = tx_out;
        busy_nxt   = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                tx_out_nxt = 1'b1;
                if (accept) begin
                    shift_nxt  = tx_data;
                    idx_nxt    = '0;
                    timer_nxt  = '0;
                    tx_out_nxt = 1'b0;
                end
            end
            START: if (bit_done) tx_out_nxt = shift[0];
            DATA: begin
                if (bit_done) begin
                    if (idx == I_LAST) begin
                        tx_out_nxt = 1'b1;
                    end else begin
                        shift_nxt  = shift_sr;
                        idx_nxt    = idx + IW'(1);
                        tx_out_nxt = shift_sr[0];
                    end
                end
            end
            STOP:    tx_out_nxt = 1'b1;
            default: tx_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer  <= '0;
            idx    <= '0;
            shift  <= '0;
            tx_out <= 1'b1;
            busy   <= 1'b0;
        end else begin
            timer  <= timer_nxt;
            idx    <= idx_nxt;
            shift  <= shift_nxt;
            tx_out <= tx_out_nxt;
            busy   <= busy_nxt;
        end
    end
endmodule
